// File: rtl/pll_lock_supervisor_if.sv
// Control/status bundle between the PLL lock supervisor and the PLL side.
// master = supervisor (drives PLL reset and status), slave = PLL/consumer side.
`timescale 1ns/1ps
interface pll_lock_supervisor_if;
  logic       pll_lock;
  logic       restart;
  logic       pll_reset;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] unlock_cnt;
  logic [1:0] state;

  modport master (
    input  pll_lock,
    input  restart,
    output pll_reset,
    output ready,
    output fail,
    output retry_cnt,
    output unlock_cnt,
    output state
  );

  modport slave (
    output pll_lock,
    output restart,
    input  pll_reset,
    input  ready,
    input  fail,
    input  retry_cnt,
    input  unlock_cnt,
    input  state
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock qualifier: holds the PLL in reset, debounces
// lock, retries on timeout / loss of lock, and gives up after a retry budget.
`timescale 1ns/1ps
module pll_lock_supervisor #(
  parameter int RST_HOLD_CYCLES     = 64,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int MAX_RETRIES         = 8
) (
  input  logic                   clkin,
  input  logic                   reset,
  pll_lock_supervisor_if.master  bus
);

  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES) + 1;
  localparam int STAB_W = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int TMR_W  = $clog2(LOCK_TIMEOUT_CYCLES) + 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
  localparam logic [3:0]        RETRY_LAST = 4'(MAX_RETRIES - 1);
  localparam logic [3:0]        RETRY_MAX  = 4'(MAX_RETRIES);

  typedef enum logic [1:0] {
    ST_RESET_HOLD = 2'b00,
    ST_WAIT_LOCK  = 2'b01,
    ST_LOCKED     = 2'b10,
    ST_FAIL       = 2'b11
  } state_t;

  state_t              state_q,      state_d;
  logic [HOLD_W-1:0]   hold_cnt_q,   hold_cnt_d;
  logic [TMR_W-1:0]    timer_q,      timer_d;
  logic [STAB_W-1:0]   stable_cnt_q, stable_cnt_d;
  logic [3:0]          retry_cnt_q,  retry_cnt_d;
  logic [7:0]          unlock_cnt_q, unlock_cnt_d;
  logic                pll_reset_q,  pll_reset_d;
  logic                ready_q,      ready_d;
  logic                fail_q,       fail_d;
  logic                sync1_q,      sync2_q;
  logic                lock_s;

  // pll_lock is asynchronous to clkin; only the twice-registered copy is trusted.
  assign lock_s = sync2_q;

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    timer_d      = timer_q;
    stable_cnt_d = stable_cnt_q;
    retry_cnt_d  = retry_cnt_q;
    unlock_cnt_d = unlock_cnt_q;
    pll_reset_d  = pll_reset_q;
    ready_d      = ready_q;
    fail_d       = fail_q;

    if (bus.restart) begin
      state_d      = ST_RESET_HOLD;
      hold_cnt_d   = '0;
      timer_d      = '0;
      stable_cnt_d = '0;
      retry_cnt_d  = '0;
      fail_d       = 1'b0;
      ready_d      = 1'b0;
      pll_reset_d  = 1'b1;
    end else begin
      case (state_q)
        ST_RESET_HOLD: begin
          pll_reset_d = 1'b1;
          ready_d     = 1'b0;
          if (hold_cnt_q == HOLD_LAST) begin
            state_d      = ST_WAIT_LOCK;
            hold_cnt_d   = '0;
            timer_d      = '0;
            stable_cnt_d = '0;
            pll_reset_d  = 1'b0;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_ONE;
          end
        end

        ST_WAIT_LOCK: begin
          timer_d      = timer_q + TMR_ONE;
          stable_cnt_d = lock_s ? (stable_cnt_q + STAB_ONE) : '0;
          // Qualification is tested first so it wins a tie with the timeout.
          if (lock_s && (stable_cnt_q == STAB_LAST)) begin
            state_d      = ST_LOCKED;
            ready_d      = 1'b1;
            retry_cnt_d  = '0;
            timer_d      = '0;
            stable_cnt_d = '0;
          end else if (timer_q == TMR_LAST) begin
            timer_d      = '0;
            stable_cnt_d = '0;
            pll_reset_d  = 1'b1;
            if (retry_cnt_q == RETRY_LAST) begin
              state_d     = ST_FAIL;
              retry_cnt_d = RETRY_MAX;
              fail_d      = 1'b1;
            end else begin
              state_d     = ST_RESET_HOLD;
              retry_cnt_d = retry_cnt_q + 4'd1;
              hold_cnt_d  = '0;
            end
          end
        end

        ST_LOCKED: begin
          if (!lock_s) begin
            state_d     = ST_RESET_HOLD;
            ready_d     = 1'b0;
            pll_reset_d = 1'b1;
            hold_cnt_d  = '0;
            if (unlock_cnt_q != 8'hFF) begin
              unlock_cnt_d = unlock_cnt_q + 8'd1;
            end
          end
        end

        ST_FAIL: begin
          pll_reset_d = 1'b1;
          ready_d     = 1'b0;
          fail_d      = 1'b1;
        end

        default: begin
          state_d     = ST_RESET_HOLD;
          hold_cnt_d  = '0;
          pll_reset_d = 1'b1;
          ready_d     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RESET_HOLD;
      hold_cnt_q   <= '0;
      timer_q      <= '0;
      stable_cnt_q <= '0;
      retry_cnt_q  <= '0;
      unlock_cnt_q <= '0;
      pll_reset_q  <= 1'b1;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      timer_q      <= timer_d;
      stable_cnt_q <= stable_cnt_d;
      retry_cnt_q  <= retry_cnt_d;
      unlock_cnt_q <= unlock_cnt_d;
      pll_reset_q  <= pll_reset_d;
      ready_q      <= ready_d;
      fail_q       <= fail_d;
      sync1_q      <= bus.pll_lock;
      sync2_q      <= sync1_q;
    end
  end

  assign bus.pll_reset  = pll_reset_q;
  assign bus.ready      = ready_q;
  assign bus.fail       = fail_q;
  assign bus.retry_cnt  = retry_cnt_q;
  assign bus.unlock_cnt = unlock_cnt_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: phase/age behavioural model compared every
// cycle, plus directed scenarios with hand-computed latencies.
`timescale 1ns/1ps
module tb_pll_lock_supervisor;

  localparam int P_H = 4;
  localparam int P_S = 8;
  localparam int P_T = 32;
  localparam int P_R = 3;

  localparam int M_HOLD = 0;
  localparam int M_WAIT = 1;
  localparam int M_LOCK = 2;
  localparam int M_FAIL = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pll_lock_supervisor_if bus();

  pll_lock_supervisor #(
    .RST_HOLD_CYCLES    (P_H),
    .LOCK_STABLE_CYCLES (P_S),
    .LOCK_TIMEOUT_CYCLES(P_T),
    .MAX_RETRIES        (P_R)
  ) dut (
    .clkin(clk),
    .reset(rst),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  // Model: current phase, cycles spent in that phase, run of synced-high lock
  // samples since the wait began, and the two event counters.
  int m_mode, m_age, m_run, m_retry, m_unlock;
  bit sh0, sh1;

  always @(posedge clk or posedge rst) begin : model
    bit ls;
    if (rst) begin
      m_mode = M_HOLD; m_age = 0; m_run = 0; m_retry = 0; m_unlock = 0;
      sh0 = 1'b0; sh1 = 1'b0;
    end else begin
      ls  = sh1;
      sh1 = sh0;
      sh0 = bus.pll_lock;
      if (bus.restart) begin
        m_mode = M_HOLD; m_age = 0; m_retry = 0;
      end else if (m_mode == M_HOLD) begin
        m_age++;
        if (m_age == P_H) begin m_mode = M_WAIT; m_age = 0; m_run = 0; end
      end else if (m_mode == M_WAIT) begin
        m_age++;
        m_run = ls ? m_run + 1 : 0;
        if (m_run == P_S) begin
          m_mode = M_LOCK; m_retry = 0;
        end else if (m_age == P_T) begin
          m_retry++;
          m_age = 0;
          m_mode = (m_retry == P_R) ? M_FAIL : M_HOLD;
        end
      end else if (m_mode == M_LOCK) begin
        if (!ls) begin
          m_mode = M_HOLD; m_age = 0;
          if (m_unlock < 255) m_unlock++;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [1:0] e_state;
    logic       e_prst, e_ready, e_fail;
    logic [3:0] e_retry;
    logic [7:0] e_unlock;
    e_state  = 2'(m_mode);
    e_prst   = (m_mode == M_HOLD) || (m_mode == M_FAIL);
    e_ready  = (m_mode == M_LOCK);
    e_fail   = (m_mode == M_FAIL);
    e_retry  = 4'(m_retry);
    e_unlock = 8'(m_unlock);
    checks++;
    if ({bus.state, bus.pll_reset, bus.ready, bus.fail, bus.retry_cnt, bus.unlock_cnt} !==
        {e_state, e_prst, e_ready, e_fail, e_retry, e_unlock}) begin
      errors++;
      $display("FAIL cycle_compare t=%0t got st=%0d prst=%0b rdy=%0b fail=%0b retry=%0d unlock=%0d required st=%0d prst=%0b rdy=%0b fail=%0b retry=%0d unlock=%0d",
               $time, bus.state, bus.pll_reset, bus.ready, bus.fail, bus.retry_cnt, bus.unlock_cnt,
               e_state, e_prst, e_ready, e_fail, e_retry, e_unlock);
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, exp);
    end else begin
      $display("ok   %s = %0d", name, got);
    end
  endtask

  function automatic bit pick(input int sel);
    case (sel)
      0:       return bus.pll_reset;
      1:       return bus.ready;
      2:       return bus.fail;
      default: return 1'b0;
    endcase
  endfunction

  // Count negedges while the selected output stays at lvl, bounded by limit.
  task automatic run_while(input int sel, input bit lvl, input int limit, output int n);
    n = 0;
    while (pick(sel) == lvl && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (pick(sel) == lvl) begin
      checks++;
      errors++;
      $display("FAIL bounded_wait sel=%0d still %0b after %0d cycles, required a change", sel, lvl, n);
    end
  endtask

  task automatic wait_state(input int st, input int limit, output int n);
    n = 0;
    while (bus.state != 2'(st) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (bus.state != 2'(st)) begin
      checks++;
      errors++;
      $display("FAIL wait_state got %0d required %0d within %0d cycles", bus.state, st, limit);
    end
  endtask

  initial begin : stim
    int n;
    bus.pll_lock = 1'b0;
    bus.restart  = 1'b0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", bus.state, 0);
    check("rst_pll_reset", bus.pll_reset, 1);
    check("rst_ready", bus.ready, 0);
    check("rst_fail", bus.fail, 0);
    check("rst_retry", bus.retry_cnt, 0);
    check("rst_unlock", bus.unlock_cnt, 0);

    // Power-up: 4-cycle hold, then lock raised at WAIT_LOCK entry.
    rst = 1'b0;
    run_while(0, 1'b1, 50, n);
    check("por_hold_len", n, 4);
    check("por_wait_state", bus.state, 1);
    bus.pll_lock = 1'b1;
    run_while(1, 1'b0, 100, n);
    check("lock_latency", n, 10);
    check("lock_retry", bus.retry_cnt, 0);
    check("lock_state", bus.state, 2);

    // Bounce: restart, then 5 high / 1 low / high in WAIT_LOCK.
    bus.pll_lock = 1'b0;
    bus.restart  = 1'b1;
    @(negedge clk);
    bus.restart  = 1'b0;
    check("restart_from_locked_state", bus.state, 0);
    wait_state(1, 50, n);
    bus.pll_lock = 1'b1;
    repeat (5) @(negedge clk);
    bus.pll_lock = 1'b0;
    @(negedge clk);
    bus.pll_lock = 1'b1;
    run_while(1, 1'b0, 100, n);
    check("bounce_latency", n + 6, 16);
    check("bounce_state", bus.state, 2);

    // Single-cycle dropout in LOCKED.
    bus.pll_lock = 1'b0;
    @(negedge clk);
    bus.pll_lock = 1'b1;
    run_while(1, 1'b1, 20, n);
    check("unlock_latency", n + 1, 3);
    check("unlock_cnt_1", bus.unlock_cnt, 1);
    check("unlock_state", bus.state, 0);
    run_while(0, 1'b1, 20, n);
    check("relock_hold_len", n, 4);
    run_while(1, 1'b0, 100, n);
    check("relock_state", bus.state, 2);
    for (int i = 1; i < 260; i++) begin
      bus.pll_lock = 1'b0;
      @(negedge clk);
      bus.pll_lock = 1'b1;
      run_while(1, 1'b1, 20, n);
      run_while(1, 1'b0, 100, n);
    end
    check("unlock_saturate", bus.unlock_cnt, 255);

    // Exhaust retries, stay in FAIL, then restart with unlock_cnt preserved.
    bus.pll_lock = 1'b0;
    wait_state(3, 500, n);
    check("fail_flag", bus.fail, 1);
    check("fail_retry", bus.retry_cnt, 3);
    check("fail_pll_reset", bus.pll_reset, 1);
    bus.pll_lock = 1'b1;
    repeat (40) @(negedge clk);
    check("fail_sticky_state", bus.state, 3);
    bus.restart = 1'b1;
    @(negedge clk);
    check("restart_state", bus.state, 0);
    check("restart_fail", bus.fail, 0);
    check("restart_retry", bus.retry_cnt, 0);
    check("restart_unlock_kept", bus.unlock_cnt, 255);
    check("restart_pll_reset", bus.pll_reset, 1);
    repeat (5) @(negedge clk);
    check("restart_held_state", bus.state, 0);
    bus.restart = 1'b0;
    run_while(0, 1'b1, 20, n);
    check("restart_hold_len", n, 4);
    run_while(1, 1'b0, 100, n);
    check("restart_relock_state", bus.state, 2);

    // Stuck-low from reset: retry steps and time to FAIL.
    rst = 1'b1;
    bus.pll_lock = 1'b0;
    @(negedge clk);
    check("reset_clears_unlock", bus.unlock_cnt, 0);
    rst = 1'b0;
    repeat (37) @(negedge clk);
    check("retry_step_1", bus.retry_cnt, 1);
    repeat (36) @(negedge clk);
    check("retry_step_2", bus.retry_cnt, 2);
    run_while(2, 1'b0, 100, n);
    check("fail_time", n + 73, 108);

    // Async reset in the middle of WAIT_LOCK (timer = 20).
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_state(1, 20, n);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_state", bus.state, 0);
    check("midreset_pll_reset", bus.pll_reset, 1);
    check("midreset_fail", bus.fail, 0);
    @(negedge clk);
    rst = 1'b0;
    run_while(0, 1'b1, 20, n);
    check("midreset_hold_len", n, 4);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
